// File: rtl/tt_hsig_pad_bridge.sv
// Pad-side bridge for a cell's hsig pad-control bundle.
// Registers pad controls, enforces OE dead-time and syncs pad_Y.
module tt_hsig_pad_bridge #(
   parameter int TURN_CYCLES = 2,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cell_A,
   input  logic             cell_OE,
   input  logic             cell_IE,
   input  logic             cell_SL,
   input  logic             cell_CS,
   input  logic             cell_PD,
   input  logic             cell_PU,
   output logic             cell_Y,
   output logic             pad_A,
   output logic             pad_OE,
   output logic             pad_IE,
   output logic             pad_SL,
   output logic             pad_CS,
   output logic             pad_PD,
   output logic             pad_PU,
   input  logic             pad_Y,
   output logic             dir_out,
   output logic             pull_err,
   output logic [CNT_W-1:0] turn_count
);

   typedef enum logic [1:0] {
      ST_IN,
      ST_TURN_OUT,
      ST_OUT,
      ST_TURN_IN
   } state_t;

   localparam logic [3:0] RELOAD =
      (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam bit NO_TURN = (TURN_CYCLES == 0);

   state_t                 state;
   logic [3:0]             dcnt;
   logic                   ie_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   enter_out;

   assign enter_out = cell_OE &&
      ((state == ST_IN && NO_TURN) ||
       (state == ST_TURN_OUT && dcnt == '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IN;
         dcnt       <= '0;
         pad_OE     <= 1'b0;
         dir_out    <= 1'b0;
         turn_count <= '0;
      end else begin
         unique case (state)
            ST_IN: begin
               if (cell_OE && !NO_TURN) begin
                  state <= ST_TURN_OUT;
                  dcnt  <= RELOAD;
               end
            end
            ST_TURN_OUT: begin
               if (!cell_OE)
                  state <= ST_IN;
               else if (dcnt != '0)
                  dcnt <= dcnt - 4'd1;
            end
            ST_OUT: begin
               if (!cell_OE) begin
                  state   <= NO_TURN ? ST_IN : ST_TURN_IN;
                  dcnt    <= RELOAD;
                  pad_OE  <= 1'b0;
                  dir_out <= 1'b0;
               end
            end
            ST_TURN_IN: begin
               if (cell_OE) begin
                  state <= ST_TURN_OUT;
                  dcnt  <= RELOAD;
               end else if (dcnt == '0) begin
                  state <= ST_IN;
               end else begin
                  dcnt <= dcnt - 4'd1;
               end
            end
            default: state <= ST_IN;
         endcase
         // Entry into OUT overrides the per-state next-state above.
         if (enter_out) begin
            state   <= ST_OUT;
            pad_OE  <= 1'b1;
            dir_out <= 1'b1;
            if (turn_count != CNT_MAX)
               turn_count <= turn_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pad_A    <= 1'b0;
         pad_SL   <= 1'b0;
         pad_CS   <= 1'b0;
         pad_PU   <= 1'b0;
         pad_PD   <= 1'b0;
         pull_err <= 1'b0;
         ie_q     <= 1'b0;
         sync_q   <= '0;
      end else begin
         pad_A    <= cell_A;
         pad_SL   <= cell_SL;
         pad_CS   <= cell_CS;
         pad_PU   <= cell_PU & ~cell_PD;
         pad_PD   <= cell_PD & ~cell_PU;
         pull_err <= pull_err | (cell_PU & cell_PD);
         ie_q     <= cell_IE;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], pad_Y};
      end
   end

   // Input path is gated off during the output-to-input dead time.
   assign pad_IE = ie_q & (state != ST_TURN_IN);
   assign cell_Y = sync_q[SYNC_STAGES-1] & pad_IE;

endmodule

// File: tb/tb_tt_hsig_pad_bridge.sv
// Randomized bench for tt_hsig_pad_bridge against a run-length
// reference model of the OE turnaround, pulls and input path.
module tb_tt_hsig_pad_bridge;

   localparam int TC = 2;
   localparam int SS = 2;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic c_a = 0, c_oe = 0, c_ie = 0, c_sl = 0;
   logic c_cs = 0, c_pd = 0, c_pu = 0, c_y = 0;
   logic cell_Y, pad_A, pad_OE, pad_IE, pad_SL, pad_CS;
   logic pad_PD, pad_PU, dir_out, pull_err;
   logic [CW-1:0] turn_count;

   int total = 0;
   int bad = 0;

   // reference model state
   int run, zrun, m_tc;
   bit reached;
   logic m_a, m_sl, m_cs, m_pu, m_pd, m_err, m_oe, m_ie, m_yv;
   logic [SS-1:0] hist;

   always #5 clk = ~clk;

   tt_hsig_pad_bridge #(
      .TURN_CYCLES(TC),
      .SYNC_STAGES(SS),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cell_A(c_a),
      .cell_OE(c_oe),
      .cell_IE(c_ie),
      .cell_SL(c_sl),
      .cell_CS(c_cs),
      .cell_PD(c_pd),
      .cell_PU(c_pu),
      .cell_Y(cell_Y),
      .pad_A(pad_A),
      .pad_OE(pad_OE),
      .pad_IE(pad_IE),
      .pad_SL(pad_SL),
      .pad_CS(pad_CS),
      .pad_PD(pad_PD),
      .pad_PU(pad_PU),
      .pad_Y(c_y),
      .dir_out(dir_out),
      .pull_err(pull_err),
      .turn_count(turn_count)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      run = 0; zrun = 0; m_tc = 0; reached = 0;
      m_a = 0; m_sl = 0; m_cs = 0; m_pu = 0; m_pd = 0;
      m_err = 0; m_oe = 0; m_ie = 0; m_yv = 0; hist = '0;
   endtask

   // pad_OE is high once cell_OE has been seen high TC+1 times in a row;
   // the input gate is shut for the first TC low samples after OUT.
   task automatic model_edge();
      bit turn_in;
      if (c_oe) begin
         if (run == 0) reached = 0;
         if (run < 1000) run++;
         if (run == TC + 1) begin
            reached = 1;
            if (m_tc < (1 << CW) - 1) m_tc++;
         end
         zrun = 0;
      end else begin
         run = 0;
         if (zrun < 1000) zrun++;
      end
      m_oe = (run >= TC + 1);
      turn_in = reached && zrun >= 1 && zrun <= TC;
      m_ie = c_ie & !turn_in;
      hist = {hist[SS-2:0], c_y};
      m_yv = hist[SS-1] & m_ie;
      m_a = c_a; m_sl = c_sl; m_cs = c_cs;
      m_pu = c_pu & ~c_pd;
      m_pd = c_pd & ~c_pu;
      m_err = m_err | (c_pu & c_pd);
   endtask

   task automatic check_all();
      check("pad_A", pad_A, m_a);
      check("pad_SL", pad_SL, m_sl);
      check("pad_CS", pad_CS, m_cs);
      check("pad_PU", pad_PU, m_pu);
      check("pad_PD", pad_PD, m_pd);
      check("pull_err", pull_err, m_err);
      check("pad_OE", pad_OE, m_oe);
      check("dir_out", dir_out, m_oe);
      check("pad_IE", pad_IE, m_ie);
      check("cell_Y", cell_Y, m_yv);
      check("turn_count", turn_count, m_tc);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_all();

      // 1: OE assert latency
      c_oe = 1;
      step();
      check("oe_lat1", pad_OE, 0);
      step();
      check("oe_lat2", pad_OE, 0);
      step();
      check("oe_lat3", pad_OE, 1);
      check("tc_first", turn_count, 1);

      // 2: data follow, then release and IE gating
      c_ie = 1;
      c_a = 1; step();
      check("a_hi", pad_A, 1);
      c_a = 0; step();
      check("a_lo", pad_A, 0);
      c_oe = 0; step();
      check("oe_rel", pad_OE, 0);
      check("ie_gate1", pad_IE, 0);
      step();
      check("ie_gate2", pad_IE, 0);
      step();
      check("ie_back", pad_IE, 1);

      // 3: one-cycle OE pulse never reaches OUT
      c_oe = 1; step();
      c_oe = 0;
      repeat (4) begin
         step();
         check("pulse_oe", pad_OE, 0);
      end
      check("pulse_tc", turn_count, 1);

      // 4: pull conflict
      c_pu = 1; c_pd = 1; step();
      check("conf_pu", pad_PU, 0);
      check("conf_pd", pad_PD, 0);
      check("conf_err", pull_err, 1);
      c_pd = 0; step();
      check("pu_only", pad_PU, 1);
      check("err_stk", pull_err, 1);

      // 5: input sync path
      c_y = 0; repeat (3) step();
      c_y = 1; step();
      check("y_lat1", cell_Y, 0);
      step();
      check("y_lat2", cell_Y, 1);
      c_ie = 0; repeat (2) step();
      check("y_gated", cell_Y, 0);

      // random phase
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 4) == 0) c_oe = ~c_oe;
         c_a = 1'($urandom); c_ie = 1'($urandom);
         c_sl = 1'($urandom); c_cs = 1'($urandom);
         c_pu = 1'($urandom); c_pd = 1'($urandom);
         c_y = 1'($urandom);
         step();
      end

      // 6: counter saturation
      for (int i = 0; i < 300; i++) begin
         c_oe = 0; step();
         c_oe = 1; repeat (3) step();
      end
      check("tc_sat", turn_count, 255);
      check("sat_out", pad_OE, 1);

      // asynchronous reset while in OUT
      reset = 1'b1;
      #1;
      check("ar_oe", pad_OE, 0);
      check("ar_dir", dir_out, 0);
      check("ar_tc", turn_count, 0);
      check("ar_err", pull_err, 0);
      model_reset();
      c_oe = 0;
      #1 reset = 1'b0;
      check_all();
      c_oe = 1;
      repeat (5) step();
      check("post_tc", turn_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tt_hsig_pad_bridge.md
Name: tt_hsig_pad_bridge

Overview:
Pad-side counterpart of a tile's hsig pad-control bundle. Accepts the cell-driven controls (A, OE, IE, SL, CS, PD, PU) and drives the physical pad with registered controls. Enforces a dead-time turnaround FSM on output-enable direction changes and resolves pull-up/pull-down conflicts. Returns the pad input Y to the cell through a synchronizer. Sits in the top level between each cell macro's hsig pins and the GF I/O pad cell.

Parameters:
TURN_CYCLES, 2, dead-time cycles with pad_OE=0 on each direction change; legal 0..15
SYNC_STAGES, 2, flops in the pad_Y synchronizer; legal 2..4
CNT_W, 8, width of the saturating turnaround counter

Ports:
clk  in  1  block clock; all flops on rising edge
reset  in  1  asynchronous, active-high reset
cell_A  in  1  output data requested by cell
cell_OE  in  1  output-enable requested by cell
cell_IE  in  1  input-enable requested by cell
cell_SL  in  1  slew select requested by cell
cell_CS  in  1  Schmitt select requested by cell
cell_PD  in  1  pull-down requested by cell
cell_PU  in  1  pull-up requested by cell
cell_Y  out  1  synchronized pad input returned to cell
pad_A  out  1  pad output data
pad_OE  out  1  pad output enable
pad_IE  out  1  pad input enable
pad_SL  out  1  pad slew select
pad_CS  out  1  pad Schmitt select
pad_PD  out  1  pad pull-down
pad_PU  out  1  pad pull-up
pad_Y  in  1  raw pad input, asynchronous to clk
dir_out  out  1  1 while FSM is in OUT
pull_err  out  1  sticky pull-conflict flag
turn_count  out  CNT_W  number of entries into OUT, saturating

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-high.
- Reset values:
  - All pad_* outputs = 0; cell_Y = 0; dir_out = 0; pull_err = 0; turn_count = 0.
  - FSM = IN; synchronizer flops = 0; dead-time counter = 0.
- Pad data and slew/Schmitt:
  - pad_A, pad_SL and pad_CS are registered copies of cell_A, cell_SL and cell_CS.
  - 1-cycle latency, independent of FSM state.
- Pulls:
  - Registered, 1-cycle latency.
  - If cell_PU=1 and cell_PD=1 in the same cycle: next cycle pad_PU=0, pad_PD=0, and pull_err sets.
  - pull_err clears only on reset.
- FSM states: IN, TURN_OUT, OUT, TURN_IN. pad_OE=1 only in OUT.
  - IN, cell_OE=1:
    - TURN_CYCLES=0: go to OUT.
    - Otherwise: go to TURN_OUT and load counter with TURN_CYCLES-1.
  - TURN_OUT:
    - cell_OE=0: return to IN; no count increment.
    - Else counter=0: go to OUT.
    - Else: decrement counter.
  - OUT, cell_OE=0: go to TURN_IN (or IN if TURN_CYCLES=0); load counter with TURN_CYCLES-1. pad_OE drops on the next cycle.
  - TURN_IN:
    - cell_OE=1: go to TURN_OUT with counter reloaded.
    - Else counter=0: go to IN.
    - Else: decrement counter.
- Timing: OE assert latency = TURN_CYCLES+1 cycles; OE release latency = 1 cycle.
- pad_IE = registered cell_IE, forced to 0 while the state is TURN_IN.
- turn_count increments on each transition into OUT and holds at 2^CNT_W-1.
- cell_Y:
  - Output of a SYNC_STAGES-deep flop chain on pad_Y, ANDed with the current pad_IE.
  - Latency from a stable pad_Y is SYNC_STAGES cycles.
- Reset asserted mid-operation immediately forces all reset values, including pad_OE=0 asynchronously.

Test Plan:
1. Reset, then cell_OE=1 held with TURN_CYCLES=2 → pad_OE rises exactly 3 cycles after the cell_OE sample; dir_out=1; turn_count=1.
2. In OUT, toggle cell_A 0→1→0 → pad_A follows with 1-cycle latency. Drop cell_OE → pad_OE=0 next cycle; pad_IE=0 for 2 cycles, then returns to cell_IE.
3. cell_OE pulse of 1 cycle from IN with TURN_CYCLES=2 → FSM returns to IN; pad_OE never asserts; turn_count unchanged.
4. cell_PU=cell_PD=1 for 1 cycle, then cell_PU=1 only → pad_PU/pad_PD=0/0 then 1/0; pull_err=1 stays until reset.
5. cell_IE=1, pad_Y steps 0→1 → cell_Y=1 after 2 cycles (SYNC_STAGES=2). With cell_IE=0, cell_Y stays 0.
6. Drive 300 OE cycles with CNT_W=8 → turn_count saturates at 255. Async reset mid-OUT → pad_OE=0 and turn_count=0 before the next clk edge.
